// File: rtl/alu_cmd_driver.sv
// Sequential initiator for the 4-bit combinational ALU: accepts requests, holds the
// operands for SETTLE_CYCLES, captures the ALU outputs and queues them in a response FIFO.
module alu_cmd_driver #(
  parameter int SETTLE_CYCLES = 2,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_op,
  input  logic [3:0]               req_a,
  input  logic [3:0]               req_b,
  output logic [3:0]               alu_a,
  output logic [3:0]               alu_b,
  output logic [2:0]               alu_cmd,
  input  logic [3:0]               alu_result,
  input  logic                     alu_carry,
  input  logic                     alu_overflow,
  input  logic                     alu_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [2:0]               rsp_op,
  output logic [3:0]               rsp_result,
  output logic [2:0]               rsp_flags,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [3:0]    SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [3:0]      settle_q, settle_d;
  logic [3:0]      alu_a_q, alu_a_d;
  logic [3:0]      alu_b_q, alu_b_d;
  logic [2:0]      alu_cmd_q, alu_cmd_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push;
  logic            pop;
  logic            space_ok;
  logic [9:0]      head;

  // Entry layout: {cmd[2:0], out, overflow, carry, result[3:0]}
  logic [9:0]      mem [DEPTH];

  assign space_ok = (count_q < DEPTH_C);

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_cmd_d = alu_cmd_q;
    req_ready = 1'b0;
    busy      = 1'b0;
    push      = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = space_ok;
        if (req_valid && space_ok) begin
          alu_a_d   = req_a;
          alu_b_d   = req_b;
          alu_cmd_d = req_op;
          settle_d  = SETTLE_LOAD;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        // Capture happens on the edge where the counter already reads zero.
        if (settle_q == '0) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop      = (count_q != '0) && rsp_ready;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      settle_q  <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_cmd_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_cmd_q <= alu_cmd_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {alu_cmd_q, alu_out, alu_overflow, alu_carry, alu_result};
  end

  assign head       = mem[rd_ptr_q];
  assign rsp_valid  = (count_q != '0);
  assign rsp_op     = head[9:7];
  assign rsp_flags  = head[6:4];
  assign rsp_result = head[3:0];
  assign count      = count_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_cmd    = alu_cmd_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Scoreboard bench for alu_cmd_driver: a 4-bit ALU model with a one-cycle transient on
// every input change, directed requests, and a monitor that checks every popped response.
module tb_alu_cmd_driver;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_op = '0;
  logic [3:0] req_a = '0;
  logic [3:0] req_b = '0;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_cmd;
  logic [3:0] alu_result;
  logic       alu_carry, alu_overflow, alu_out;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [2:0] rsp_op;
  logic [3:0] rsp_result;
  logic [2:0] rsp_flags;
  logic       busy;
  logic [$clog2(DEPTH):0] count;

  int n_checks = 0;
  int n_pass   = 0;
  logic [9:0] sb [$];

  alu_cmd_driver #(.SETTLE_CYCLES(2), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_overflow(alu_overflow), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  // Returns {out, overflow, carry, result}
  function automatic logic [6:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] r;
    logic c, v;
    s = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'b000: begin
        s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4];
        v = (a[3] == b[3]) && (r[3] != a[3]);
      end
      3'b001: begin
        s = {1'b0, a} - {1'b0, b}; r = s[3:0]; c = ~s[4];
        v = (a[3] != b[3]) && (r[3] != a[3]);
      end
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b100:  r = a ^ b;
      default: r = ~a;
    endcase
    return {r[3], v, c, r};
  endfunction

  // ALU model: result reads 4'h3 for the first cycle after any input change.
  logic [10:0] last_in;
  logic [6:0]  alu_settled;
  always @(posedge clk) last_in <= {alu_cmd, alu_a, alu_b};
  always_comb begin
    alu_settled  = alu_ref(alu_cmd, alu_a, alu_b);
    alu_out      = alu_settled[6];
    alu_overflow = alu_settled[5];
    alu_carry    = alu_settled[4];
    alu_result   = ({alu_cmd, alu_a, alu_b} !== last_in) ? 4'h3 : alu_settled[3:0];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: the head is popped on the next rising edge when valid && ready at the falling edge.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", {22'd0, rsp_op, rsp_flags, rsp_result}, 32'h3ff);
      end else begin
        logic [9:0] e;
        e = sb.pop_front();
        check("rsp_entry", {22'd0, rsp_op, rsp_flags, rsp_result}, {22'd0, e});
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                      input bit exp_en, input logic [9:0] exp);
    int n;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) begin
      check("req_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk); #1;
      if (exp_en) sb.push_back(exp);
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (busy) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n;
    rsp_ready = 1'b1;
    n = 0;
    while (count != 0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    rsp_ready = 1'b0;
    check("drain_count", 32'(count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [6:0] r;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_alu_cmd", 32'(alu_cmd), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_req_ready", 32'(req_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // Single ADD 7+9: latency and busy width
    send(3'b000, 4'h7, 4'h9, 1'b1, {3'b000, 3'b001, 4'h0});
    check("add_alu_a", 32'(alu_a), 32'd7);
    check("add_alu_b", 32'(alu_b), 32'd9);
    check("add_alu_cmd", 32'(alu_cmd), 32'd0);
    check("add_busy_k", 32'(busy), 32'd1);
    check("add_req_ready_wait", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check("add_busy_k1", 32'(busy), 32'd1);
    check("add_rsp_valid_k1", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    check("add_busy_k2", 32'(busy), 32'd0);
    check("add_rsp_valid_k2", 32'(rsp_valid), 32'd1);
    check("add_count_k2", 32'(count), 32'd1);
    check("add_rsp_result", 32'(rsp_result), 32'h0);
    check("add_rsp_flags", 32'(rsp_flags), 32'b001);
    drain();
    check("alu_a_retained", 32'(alu_a), 32'd7);

    // Settle enforcement and assorted operations
    rsp_ready = 1'b1;
    send(3'b000, 4'h5, 4'h7, 1'b1, {3'b000, 3'b110, 4'hC});
    wait_idle();
    send(3'b001, 4'h3, 4'h5, 1'b1, {3'b001, 3'b100, 4'hE});
    send(3'b010, 4'hC, 4'hA, 1'b1, {3'b010, 3'b100, 4'h8});
    send(3'b100, 4'h6, 4'h3, 1'b1, {3'b100, 3'b000, 4'h5});
    send(3'b000, 4'h8, 4'h8, 1'b1, {3'b000, 3'b011, 4'h0});
    wait_idle();
    drain();

    // Full FIFO
    for (int i = 1; i <= 4; i++)
      send(3'b000, 4'(i), 4'h1, 1'b1, {3'b000, 3'b000, 4'(i + 1)});
    wait_idle();
    check("full_count", 32'(count), 32'd4);
    check("full_req_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b1; req_op = 3'b000; req_a = 4'h5; req_b = 4'h1;
    repeat (3) begin @(posedge clk); #1; end
    check("full_not_accepted", 32'(busy), 32'd0);
    check("full_count_held", 32'(count), 32'd4);
    sb.push_back({3'b000, 3'b000, 4'h6});
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("pop_req_ready", 32'(req_ready), 32'd1);
    check("pop_count", 32'(count), 32'd3);
    @(posedge clk); #1;
    check("fifth_accepted", 32'(busy), 32'd1);
    req_valid = 1'b0;
    wait_idle();
    check("refill_count", 32'(count), 32'd4);
    drain();

    // Simultaneous push and pop at count == 1
    send(3'b000, 4'h1, 4'h1, 1'b1, {3'b000, 3'b000, 4'h2});
    wait_idle();
    send(3'b000, 4'h2, 4'h2, 1'b1, {3'b000, 3'b000, 4'h4});
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("pushpop_count", 32'(count), 32'd1);
    check("pushpop_head", 32'(rsp_result), 32'h4);
    drain();

    // Back-to-back operations across pointer wrap
    rsp_ready = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      r = alu_ref(3'b000, 4'(i), 4'h2);
      send(3'b000, 4'(i), 4'h2, 1'b1, {3'b000, r});
    end
    wait_idle();
    drain();

    // Reset mid-WAIT with two entries queued
    send(3'b000, 4'h1, 4'h2, 1'b0, '0);
    send(3'b000, 4'h3, 4'h4, 1'b0, '0);
    wait_idle();
    check("pre_rst_count", 32'(count), 32'd2);
    send(3'b000, 4'h5, 4'h6, 1'b0, '0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    check("post_rst_count", 32'(count), 32'd0);
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b0;

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
